icache_ifill_arbiter: RTL and testbench

Shares the single upper-level instruction-fill port between two requesters: the icache demand-miss path and a next-line prefetcher. It sits between the icache top level and the L2/ifill interface. It grants one line fill at a time, sequences the request/ack handshake and the beat stream, and routes returning beats to the owner. It also handles flush by draining in-flight beats.

---
 rtl/drac_icache_pkg.sv | 19 +
 rtl/icache_ifill_arbiter.sv | 158 +++++++++++++++
 tb/tb_icache_ifill_arbiter.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/drac_icache_pkg.sv
// Shared icache types and constants.
// Holds the fill-arbiter state/owner encodings and the line beat count.
package drac_icache_pkg;

    localparam int ICACHE_FILL_BEATS = 4;

    typedef enum logic [1:0] {
        IFILL_IDLE,
        IFILL_REQ,
        IFILL_FILL,
        IFILL_DRAIN
    } ifill_arb_state_t;

    typedef enum logic {
        IFILL_OWNER_DMD,
        IFILL_OWNER_PF
    } ifill_owner_t;

endpackage

// File: rtl/icache_ifill_arbiter.sv
// Arbitrates the single upper-level fill port between demand and prefetch.
// One line fill at a time; beats are routed to the owner or drained on flush.
module icache_ifill_arbiter
    import drac_icache_pkg::*;
#(
    parameter int PADDR_WIDTH = 34,
    parameter int WAY_WIDTH   = 2,
    parameter int DATA_WIDTH  = 128,
    parameter int N_BEATS     = ICACHE_FILL_BEATS
) (
    input  logic                       clk_i,
    input  logic                       rstn_i,
    input  logic                       flush_i,
    input  logic                       dmd_req_valid_i,
    input  logic [PADDR_WIDTH-1:0]     dmd_req_paddr_i,
    input  logic [WAY_WIDTH-1:0]       dmd_req_way_i,
    output logic                       dmd_req_ready_o,
    input  logic                       pf_req_valid_i,
    input  logic [PADDR_WIDTH-1:0]     pf_req_paddr_i,
    input  logic [WAY_WIDTH-1:0]       pf_req_way_i,
    output logic                       pf_req_ready_o,
    output logic                       up_req_valid_o,
    output logic [PADDR_WIDTH-1:0]     up_req_paddr_o,
    output logic [WAY_WIDTH-1:0]       up_req_way_o,
    input  logic                       up_req_ack_i,
    input  logic                       up_resp_valid_i,
    input  logic [$clog2(N_BEATS)-1:0] up_resp_beat_i,
    input  logic [DATA_WIDTH-1:0]      up_resp_data_i,
    output logic                       dmd_resp_valid_o,
    output logic                       pf_resp_valid_o,
    output logic [$clog2(N_BEATS)-1:0] resp_beat_o,
    output logic [DATA_WIDTH-1:0]      resp_data_o,
    output logic                       dmd_done_o,
    output logic                       pf_done_o,
    output logic                       beat_err_o,
    output logic                       busy_o
);

    localparam int BEAT_W = $clog2(N_BEATS);

    ifill_arb_state_t         state_q, state_d;
    ifill_owner_t             owner_q, owner_d;
    logic [BEAT_W-1:0]        cnt_q, cnt_d;
    logic                     flush_seen_q, flush_seen_d;
    logic [PADDR_WIDTH-1:0]   paddr_q, paddr_d;
    logic [WAY_WIDTH-1:0]     way_q, way_d;

    logic beat_ok;
    logic last_beat;
    logic route;
    logic done;

    assign beat_ok   = (up_resp_beat_i == cnt_q);
    assign last_beat = (cnt_q == BEAT_W'(N_BEATS - 1));

    always_comb begin
        state_d         = state_q;
        owner_d         = owner_q;
        cnt_d           = cnt_q;
        flush_seen_d    = flush_seen_q;
        paddr_d         = paddr_q;
        way_d           = way_q;
        dmd_req_ready_o = 1'b0;
        pf_req_ready_o  = 1'b0;
        beat_err_o      = 1'b0;
        route           = 1'b0;
        done            = 1'b0;

        unique case (state_q)
            IFILL_IDLE: begin
                beat_err_o = up_resp_valid_i;
                if (!flush_i) begin
                    if (dmd_req_valid_i) begin
                        dmd_req_ready_o = 1'b1;
                        paddr_d         = dmd_req_paddr_i;
                        way_d           = dmd_req_way_i;
                        owner_d         = IFILL_OWNER_DMD;
                    end else if (pf_req_valid_i) begin
                        pf_req_ready_o = 1'b1;
                        paddr_d        = pf_req_paddr_i;
                        way_d          = pf_req_way_i;
                        owner_d        = IFILL_OWNER_PF;
                    end
                end
                if (dmd_req_ready_o || pf_req_ready_o) begin
                    cnt_d        = '0;
                    flush_seen_d = 1'b0;
                    state_d      = IFILL_REQ;
                end
            end
            IFILL_REQ: begin
                beat_err_o = up_resp_valid_i;
                if (flush_i) flush_seen_d = 1'b1;
                // A demand miss to the line already being prefetched joins it.
                if (owner_q == IFILL_OWNER_PF && dmd_req_valid_i &&
                    dmd_req_paddr_i == paddr_q) begin
                    dmd_req_ready_o = 1'b1;
                    owner_d         = IFILL_OWNER_DMD;
                end
                if (up_req_ack_i) begin
                    state_d = (flush_seen_q || flush_i) ? IFILL_DRAIN
                                                        : IFILL_FILL;
                end
            end
            IFILL_FILL: begin
                if (up_resp_valid_i) begin
                    cnt_d      = BEAT_W'(cnt_q + 1'b1);
                    beat_err_o = !beat_ok;
                    route      = !flush_i;
                    done       = !flush_i && last_beat;
                end
                if (up_resp_valid_i && last_beat) begin
                    state_d = IFILL_IDLE;
                end else if (flush_i) begin
                    state_d = IFILL_DRAIN;
                end
            end
            IFILL_DRAIN: begin
                if (up_resp_valid_i) begin
                    cnt_d      = BEAT_W'(cnt_q + 1'b1);
                    beat_err_o = !beat_ok;
                    if (last_beat) state_d = IFILL_IDLE;
                end
            end
            default: state_d = IFILL_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rstn_i) begin
            state_q      <= IFILL_IDLE;
            owner_q      <= IFILL_OWNER_DMD;
            cnt_q        <= '0;
            flush_seen_q <= 1'b0;
            paddr_q      <= '0;
            way_q        <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            cnt_q        <= cnt_d;
            flush_seen_q <= flush_seen_d;
            paddr_q      <= paddr_d;
            way_q        <= way_d;
        end
    end

    assign up_req_valid_o   = (state_q == IFILL_REQ);
    assign up_req_paddr_o   = paddr_q;
    assign up_req_way_o     = way_q;
    assign busy_o           = (state_q != IFILL_IDLE);
    assign resp_beat_o      = up_resp_beat_i;
    assign resp_data_o      = up_resp_data_i;
    assign dmd_resp_valid_o = route && (owner_q == IFILL_OWNER_DMD);
    assign pf_resp_valid_o  = route && (owner_q == IFILL_OWNER_PF);
    assign dmd_done_o       = done && (owner_q == IFILL_OWNER_DMD);
    assign pf_done_o        = done && (owner_q == IFILL_OWNER_PF);

endmodule

// File: tb/tb_icache_ifill_arbiter.sv
// Directed per-cycle vector bench for icache_ifill_arbiter.
// Each row holds one cycle of inputs and the outputs expected in that cycle.
module tb_icache_ifill_arbiter;

    localparam int PW = 34;
    localparam int WW = 2;
    localparam int DW = 128;
    localparam int NB = 4;
    localparam int BW = 2;

    // in:  {rstn, flush, dmd_v, pf_v, ack, resp_v}
    // out: {dmd_rdy, pf_rdy, up_v, dmd_rv, pf_rv, dmd_done, pf_done, err, busy}
    typedef struct {
        logic [5:0]    in;
        logic [PW-1:0] dpa;
        logic [PW-1:0] ppa;
        logic [WW-1:0] dw;
        logic [WW-1:0] pw;
        logic [BW-1:0] beat;
        logic [8:0]    out;
        logic [PW-1:0] epa;
        logic [WW-1:0] ew;
    } vec_t;

    logic          clk = 1'b0;
    logic          rstn_i, flush_i;
    logic          dmd_req_valid_i, pf_req_valid_i;
    logic [PW-1:0] dmd_req_paddr_i, pf_req_paddr_i;
    logic [WW-1:0] dmd_req_way_i, pf_req_way_i;
    logic          dmd_req_ready_o, pf_req_ready_o;
    logic          up_req_valid_o;
    logic [PW-1:0] up_req_paddr_o;
    logic [WW-1:0] up_req_way_o;
    logic          up_req_ack_i, up_resp_valid_i;
    logic [BW-1:0] up_resp_beat_i;
    logic [DW-1:0] up_resp_data_i;
    logic          dmd_resp_valid_o, pf_resp_valid_o;
    logic [BW-1:0] resp_beat_o;
    logic [DW-1:0] resp_data_o;
    logic          dmd_done_o, pf_done_o, beat_err_o, busy_o;

    int n_checks = 0;
    int n_fail   = 0;
    vec_t vecs[$];

    always #5 clk = ~clk;

    icache_ifill_arbiter #(
        .PADDR_WIDTH(PW), .WAY_WIDTH(WW),
        .DATA_WIDTH(DW), .N_BEATS(NB)
    ) dut (
        .clk_i(clk), .rstn_i(rstn_i), .flush_i(flush_i),
        .dmd_req_valid_i(dmd_req_valid_i),
        .dmd_req_paddr_i(dmd_req_paddr_i),
        .dmd_req_way_i(dmd_req_way_i),
        .dmd_req_ready_o(dmd_req_ready_o),
        .pf_req_valid_i(pf_req_valid_i),
        .pf_req_paddr_i(pf_req_paddr_i),
        .pf_req_way_i(pf_req_way_i),
        .pf_req_ready_o(pf_req_ready_o),
        .up_req_valid_o(up_req_valid_o),
        .up_req_paddr_o(up_req_paddr_o),
        .up_req_way_o(up_req_way_o),
        .up_req_ack_i(up_req_ack_i),
        .up_resp_valid_i(up_resp_valid_i),
        .up_resp_beat_i(up_resp_beat_i),
        .up_resp_data_i(up_resp_data_i),
        .dmd_resp_valid_o(dmd_resp_valid_o),
        .pf_resp_valid_o(pf_resp_valid_o),
        .resp_beat_o(resp_beat_o),
        .resp_data_o(resp_data_o),
        .dmd_done_o(dmd_done_o),
        .pf_done_o(pf_done_o),
        .beat_err_o(beat_err_o),
        .busy_o(busy_o)
    );

    function automatic vec_t mk(
        input logic [5:0] in, input logic [PW-1:0] dpa,
        input logic [PW-1:0] ppa, input logic [WW-1:0] dw,
        input logic [WW-1:0] pw, input logic [BW-1:0] beat,
        input logic [8:0] out, input logic [PW-1:0] epa,
        input logic [WW-1:0] ew);
        vec_t v;
        v.in = in; v.dpa = dpa; v.ppa = ppa; v.dw = dw; v.pw = pw;
        v.beat = beat; v.out = out; v.epa = epa; v.ew = ew;
        return v;
    endfunction

    task automatic r(
        input logic [5:0] in, input logic [PW-1:0] dpa,
        input logic [PW-1:0] ppa, input logic [WW-1:0] dw,
        input logic [WW-1:0] pw, input logic [BW-1:0] beat,
        input logic [8:0] out, input logic [PW-1:0] epa,
        input logic [WW-1:0] ew);
        vecs.push_back(mk(in, dpa, ppa, dw, pw, beat, out, epa, ew));
    endtask

    task automatic chk(input string name, input int idx,
                       input logic [PW-1:0] act, input logic [PW-1:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s row %0d: got %0h expected %0h",
                     name, idx, act, exp);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        logic [DW-1:0] data;
        logic [8:0]    got;
        @(negedge clk);
        data            = {4{idx[31:0] ^ 32'hA5C3_0000}};
        rstn_i          = v.in[5];
        flush_i         = v.in[4];
        dmd_req_valid_i = v.in[3];
        pf_req_valid_i  = v.in[2];
        up_req_ack_i    = v.in[1];
        up_resp_valid_i = v.in[0];
        dmd_req_paddr_i = v.dpa;
        pf_req_paddr_i  = v.ppa;
        dmd_req_way_i   = v.dw;
        pf_req_way_i    = v.pw;
        up_resp_beat_i  = v.beat;
        up_resp_data_i  = data;
        #1;
        got = {dmd_req_ready_o, pf_req_ready_o, up_req_valid_o,
               dmd_resp_valid_o, pf_resp_valid_o, dmd_done_o,
               pf_done_o, beat_err_o, busy_o};
        chk("flags", idx, PW'(got), PW'(v.out));
        chk("paddr", idx, up_req_paddr_o, v.epa);
        chk("way", idx, PW'(up_req_way_o), PW'(v.ew));
        chk("beat", idx, PW'(resp_beat_o), PW'(v.beat));
        n_checks++;
        if (resp_data_o !== data) begin
            n_fail++;
            $display("FAIL data row %0d: got %0h expected %0h",
                     idx, resp_data_o, data);
        end
    endtask

    initial begin
        rstn_i = 1'b0; flush_i = 1'b0;
        dmd_req_valid_i = 1'b0; pf_req_valid_i = 1'b0;
        dmd_req_paddr_i = '0; pf_req_paddr_i = '0;
        dmd_req_way_i = '0; pf_req_way_i = '0;
        up_req_ack_i = 1'b0; up_resp_valid_i = 1'b0;
        up_resp_beat_i = '0; up_resp_data_i = '0;
        repeat (2) @(posedge clk);

        // reset state
        r(6'b000000, 0, 0, 0, 0, 0, 9'b000000000, 0, 0);
        // demand only, 0x12345 way 2
        r(6'b101000, 'h12345, 0, 2, 0, 0, 9'b100000000, 0, 0);
        r(6'b100000, 0, 0, 0, 0, 0, 9'b001000001, 'h12345, 2);
        r(6'b100010, 0, 0, 0, 0, 0, 9'b001000001, 'h12345, 2);
        r(6'b100001, 0, 0, 0, 0, 0, 9'b000100001, 'h12345, 2);
        r(6'b100001, 0, 0, 0, 0, 1, 9'b000100001, 'h12345, 2);
        r(6'b100001, 0, 0, 0, 0, 2, 9'b000100001, 'h12345, 2);
        r(6'b100001, 0, 0, 0, 0, 3, 9'b000101001, 'h12345, 2);
        r(6'b100000, 0, 0, 0, 0, 0, 9'b000000000, 'h12345, 2);
        // demand beats prefetch; prefetch granted right after done
        r(6'b101100, 'h100, 'h200, 1, 3, 0, 9'b100000000, 'h12345, 2);
        r(6'b100100, 0, 'h200, 0, 3, 0, 9'b001000001, 'h100, 1);
        r(6'b100110, 0, 'h200, 0, 3, 0, 9'b001000001, 'h100, 1);
        r(6'b100101, 0, 'h200, 0, 3, 0, 9'b000100001, 'h100, 1);
        r(6'b100101, 0, 'h200, 0, 3, 1, 9'b000100001, 'h100, 1);
        r(6'b100101, 0, 'h200, 0, 3, 2, 9'b000100001, 'h100, 1);
        r(6'b100101, 0, 'h200, 0, 3, 3, 9'b000101001, 'h100, 1);
        r(6'b100100, 0, 'h200, 0, 3, 0, 9'b010000000, 'h100, 1);
        r(6'b100000, 0, 0, 0, 0, 0, 9'b001000001, 'h200, 3);
        r(6'b100010, 0, 0, 0, 0, 0, 9'b001000001, 'h200, 3);
        r(6'b100001, 0, 0, 0, 0, 0, 9'b000010001, 'h200, 3);
        r(6'b100001, 0, 0, 0, 0, 1, 9'b000010001, 'h200, 3);
        r(6'b100001, 0, 0, 0, 0, 2, 9'b000010001, 'h200, 3);
        r(6'b100001, 0, 0, 0, 0, 3, 9'b000010101, 'h200, 3);
        // prefetch 0x400 promoted by matching demand; mismatch first
        r(6'b100100, 0, 'h400, 0, 0, 0, 9'b010000000, 'h200, 3);
        r(6'b101000, 'h401, 0, 1, 0, 0, 9'b001000001, 'h400, 0);
        r(6'b101000, 'h400, 0, 1, 0, 0, 9'b101000001, 'h400, 0);
        r(6'b100010, 0, 0, 0, 0, 0, 9'b001000001, 'h400, 0);
        r(6'b100001, 0, 0, 0, 0, 0, 9'b000100001, 'h400, 0);
        r(6'b100001, 0, 0, 0, 0, 1, 9'b000100001, 'h400, 0);
        r(6'b100001, 0, 0, 0, 0, 2, 9'b000100001, 'h400, 0);
        r(6'b100001, 0, 0, 0, 0, 3, 9'b000101001, 'h400, 0);
        r(6'b100000, 0, 0, 0, 0, 0, 9'b000000000, 'h400, 0);
        // flush in FILL after beat 1, then a normal fill
        r(6'b101000, 'habc, 0, 3, 0, 0, 9'b100000000, 'h400, 0);
        r(6'b100000, 0, 0, 0, 0, 0, 9'b001000001, 'habc, 3);
        r(6'b100010, 0, 0, 0, 0, 0, 9'b001000001, 'habc, 3);
        r(6'b100001, 0, 0, 0, 0, 0, 9'b000100001, 'habc, 3);
        r(6'b100001, 0, 0, 0, 0, 1, 9'b000100001, 'habc, 3);
        r(6'b110000, 0, 0, 0, 0, 0, 9'b000000001, 'habc, 3);
        r(6'b100001, 0, 0, 0, 0, 2, 9'b000000001, 'habc, 3);
        r(6'b100001, 0, 0, 0, 0, 3, 9'b000000001, 'habc, 3);
        r(6'b101000, 'hdef, 0, 0, 0, 0, 9'b100000000, 'habc, 3);
        r(6'b100000, 0, 0, 0, 0, 0, 9'b001000001, 'hdef, 0);
        r(6'b100010, 0, 0, 0, 0, 0, 9'b001000001, 'hdef, 0);
        r(6'b100001, 0, 0, 0, 0, 0, 9'b000100001, 'hdef, 0);
        r(6'b100001, 0, 0, 0, 0, 1, 9'b000100001, 'hdef, 0);
        r(6'b100001, 0, 0, 0, 0, 2, 9'b000100001, 'hdef, 0);
        r(6'b100001, 0, 0, 0, 0, 3, 9'b000101001, 'hdef, 0);
        // flush in REQ before ack: request held, beats drained
        r(6'b101000, 'h777, 0, 1, 0, 0, 9'b100000000, 'hdef, 0);
        r(6'b110000, 0, 0, 0, 0, 0, 9'b001000001, 'h777, 1);
        r(6'b100000, 0, 0, 0, 0, 0, 9'b001000001, 'h777, 1);
        r(6'b100010, 0, 0, 0, 0, 0, 9'b001000001, 'h777, 1);
        r(6'b100001, 0, 0, 0, 0, 0, 9'b000000001, 'h777, 1);
        r(6'b100001, 0, 0, 0, 0, 1, 9'b000000001, 'h777, 1);
        r(6'b100001, 0, 0, 0, 0, 2, 9'b000000001, 'h777, 1);
        r(6'b100001, 0, 0, 0, 0, 3, 9'b000000001, 'h777, 1);
        r(6'b100000, 0, 0, 0, 0, 0, 9'b000000000, 'h777, 1);
        // beat order 0,2,1,3
        r(6'b101000, 'h555, 0, 2, 0, 0, 9'b100000000, 'h777, 1);
        r(6'b100000, 0, 0, 0, 0, 0, 9'b001000001, 'h555, 2);
        r(6'b100010, 0, 0, 0, 0, 0, 9'b001000001, 'h555, 2);
        r(6'b100001, 0, 0, 0, 0, 0, 9'b000100001, 'h555, 2);
        r(6'b100001, 0, 0, 0, 0, 2, 9'b000100011, 'h555, 2);
        r(6'b100001, 0, 0, 0, 0, 1, 9'b000100011, 'h555, 2);
        r(6'b100001, 0, 0, 0, 0, 3, 9'b000101001, 'h555, 2);
        r(6'b100000, 0, 0, 0, 0, 0, 9'b000000000, 'h555, 2);
        // flush blocks IDLE grant; flush with last beat -> no done
        r(6'b111000, 'h666, 0, 1, 0, 0, 9'b000000000, 'h555, 2);
        r(6'b101000, 'h666, 0, 1, 0, 0, 9'b100000000, 'h555, 2);
        r(6'b100000, 0, 0, 0, 0, 0, 9'b001000001, 'h666, 1);
        r(6'b100010, 0, 0, 0, 0, 0, 9'b001000001, 'h666, 1);
        r(6'b100001, 0, 0, 0, 0, 0, 9'b000100001, 'h666, 1);
        r(6'b100001, 0, 0, 0, 0, 1, 9'b000100001, 'h666, 1);
        r(6'b100001, 0, 0, 0, 0, 2, 9'b000100001, 'h666, 1);
        r(6'b110001, 0, 0, 0, 0, 3, 9'b000000001, 'h666, 1);
        r(6'b100000, 0, 0, 0, 0, 0, 9'b000000000, 'h666, 1);
        // stray beat in IDLE
        r(6'b100001, 0, 0, 0, 0, 1, 9'b000000010, 'h666, 1);
        // ack and flush together in REQ -> drain
        r(6'b101000, 'h321, 0, 0, 0, 0, 9'b100000000, 'h666, 1);
        r(6'b100000, 0, 0, 0, 0, 0, 9'b001000001, 'h321, 0);
        r(6'b110010, 0, 0, 0, 0, 0, 9'b001000001, 'h321, 0);
        r(6'b100001, 0, 0, 0, 0, 0, 9'b000000001, 'h321, 0);
        r(6'b100001, 0, 0, 0, 0, 1, 9'b000000001, 'h321, 0);
        r(6'b100001, 0, 0, 0, 0, 2, 9'b000000001, 'h321, 0);
        r(6'b100001, 0, 0, 0, 0, 3, 9'b000000001, 'h321, 0);
        r(6'b100000, 0, 0, 0, 0, 0, 9'b000000000, 'h321, 0);

        for (int i = 0; i < vecs.size(); i++) apply(vecs[i], i);

        // reset in the middle of a fill; later beats only flag errors
        apply(mk(6'b101000, 'h999, 0, 1, 0, 0, 9'b100000000, 'h321, 0), 1000);
        apply(mk(6'b100000, 0, 0, 0, 0, 0, 9'b001000001, 'h999, 1), 1001);
        apply(mk(6'b100010, 0, 0, 0, 0, 0, 9'b001000001, 'h999, 1), 1002);
        apply(mk(6'b100001, 0, 0, 0, 0, 0, 9'b000100001, 'h999, 1), 1003);
        apply(mk(6'b000001, 0, 0, 0, 0, 1, 9'b000100001, 'h999, 1), 1004);
        apply(mk(6'b100001, 0, 0, 0, 0, 2, 9'b000000010, 0, 0), 1005);
        apply(mk(6'b100001, 0, 0, 0, 0, 3, 9'b000000010, 0, 0), 1006);
        apply(mk(6'b100000, 0, 0, 0, 0, 0, 9'b000000000, 0, 0), 1007);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
